// File: rtl/tcdm_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tcdm_resp_pkg
//  Brief   : Shared types and helpers for the TCDM bank responder and the
//            crossbar-side wrappers that consume its response stream.
//  Revision: 1.0 - initial release
// ============================================================================
package tcdm_resp_pkg;

   // Index width for a given initiator count; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned num_in);
      return (num_in > 1) ? $clog2(num_in) : 1;
   endfunction

   localparam int unsigned DefaultNumIn         = 4;
   localparam int unsigned DefaultIdxW          = idx_width(DefaultNumIn);
   localparam int unsigned DefaultRespDataWidth = 32;

   // Response record {idx, rdata} at the default widths. Modules built with
   // other widths declare a struct of the same shape and pass it as a type
   // parameter to the FIFO.
   typedef struct packed {
      logic [DefaultIdxW-1:0]          idx;
      logic [DefaultRespDataWidth-1:0] rdata;
   } resp_t;

endpackage
`default_nettype wire

// File: rtl/tcdm_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tcdm_resp_fifo
//  Brief   : Registered, non-fall-through FIFO of arbitrary depth. The head
//            entry is visible the cycle after it was pushed.
//  Revision: 1.0 - initial release
// ============================================================================
module tcdm_resp_fifo
   import tcdm_resp_pkg::*;
#(
   parameter int unsigned Depth   = 3,
   parameter type         entry_t = resp_t,
   localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW   = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  entry_t          data_i,
   input  logic            pop_i,
   output entry_t          data_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   entry_t            mem_q [Depth];
   logic [PtrW-1:0]   rptr_q, rptr_d;
   logic [PtrW-1:0]   wptr_q, wptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              push_en, pop_en;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;

   // Next pointer and occupancy; simultaneous push and pop are both honoured.
   always_comb begin
      rptr_d  = pop_en  ? ptr_inc(rptr_q) : rptr_q;
      wptr_d  = push_en ? ptr_inc(wptr_q) : wptr_q;
      count_d = count_q + CntW'(push_en) - CntW'(pop_en);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are don't-care while not counted as occupied.
   always_ff @(posedge clk_i) begin
      if (push_en) begin
         mem_q[wptr_q] <= data_i;
      end
   end

`ifndef SYNTHESIS
   // The credit scheme upstream makes a push into a full FIFO impossible.
   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push_i |-> !full_o)
      else $error("tcdm_resp_fifo: push into full FIFO");
`endif

endmodule
`default_nettype wire

// File: rtl/tcdm_bank_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tcdm_bank_responder
//  Brief   : Crossbar target endpoint in front of a fixed-latency SRAM bank.
//            Credit-based grants guarantee a response slot for every
//            accepted request; responses return in grant order.
//  Revision: 1.0 - initial release
// ============================================================================
module tcdm_bank_responder
   import tcdm_resp_pkg::*;
#(
   parameter int unsigned NumIn         = 4,
   parameter int unsigned ReqDataWidth  = 32,
   parameter int unsigned RespDataWidth = 32,
   parameter int unsigned MemLatency    = 1,
   parameter int unsigned RespDepth     = 3,
   localparam int unsigned IdxW         = idx_width(NumIn)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_i,
   input  logic [IdxW-1:0]          idx_i,
   input  logic [ReqDataWidth-1:0]  wdata_i,
   output logic                     gnt_o,
   output logic                     mem_req_o,
   output logic [ReqDataWidth-1:0]  mem_wdata_o,
   input  logic [RespDataWidth-1:0] mem_rdata_i,
   output logic                     vld_o,
   input  logic                     rdy_i,
   output logic [IdxW-1:0]          idx_o,
   output logic [RespDataWidth-1:0] rdata_o
);

   localparam int unsigned CntW = $clog2(RespDepth + 1);

   if (NumIn < 1) begin : g_chk_numin
      $fatal(1, "tcdm_bank_responder: NumIn must be >= 1");
   end
   if (MemLatency < 1) begin : g_chk_lat
      $fatal(1, "tcdm_bank_responder: MemLatency must be >= 1");
   end
   if (RespDepth < 1) begin : g_chk_depth
      $fatal(1, "tcdm_bank_responder: RespDepth must be >= 1");
   end
   if (RespDepth < MemLatency + 2) begin : g_chk_thru
      $warning("tcdm_bank_responder: RespDepth < MemLatency+2 limits throughput");
   end

   typedef struct packed {
      logic [IdxW-1:0]          idx;
      logic [RespDataWidth-1:0] rdata;
   } resp_local_t;

   logic [CntW-1:0]       credits_q, credits_d;
   logic [MemLatency-1:0] lat_vld_q;
   logic [IdxW-1:0]       lat_idx_q [MemLatency];
   logic                  pop;
   logic                  fifo_full, fifo_empty;
   logic [CntW-1:0]       fifo_count;
   resp_local_t           push_data, head;

   // Grant depends only on the request and the credit register, never on rdy_i.
   assign gnt_o       = req_i && (credits_q != '0);
   assign mem_req_o   = gnt_o;
   assign mem_wdata_o = wdata_i;
   assign pop         = vld_o && rdy_i;

   // A grant consumes a credit; a response leaving the FIFO returns one.
   always_comb begin
      credits_d = credits_q - CntW'(gnt_o) + CntW'(pop);
   end

   // Credit register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         credits_q <= CntW'(RespDepth);
      end else begin
         credits_q <= credits_d;
      end
   end

   // Latency shift register tracking which bank cycles return valid data.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lat_vld_q <= '0;
      end else begin
         lat_vld_q[0] <= gnt_o;
         for (int k = 1; k < int'(MemLatency); k++) begin
            lat_vld_q[k] <= lat_vld_q[k-1];
         end
      end
   end

   // Initiator index travels alongside the valid bit; no reset needed.
   always_ff @(posedge clk_i) begin
      lat_idx_q[0] <= idx_i;
      for (int k = 1; k < int'(MemLatency); k++) begin
         lat_idx_q[k] <= lat_idx_q[k-1];
      end
   end

   assign push_data = '{idx: lat_idx_q[MemLatency-1], rdata: mem_rdata_i};

   tcdm_resp_fifo #(
      .Depth   (RespDepth),
      .entry_t (resp_local_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (lat_vld_q[MemLatency-1]),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign vld_o   = !fifo_empty;
   assign idx_o   = head.idx;
   assign rdata_o = head.rdata;

`ifndef SYNTHESIS
   a_credit_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      credits_q <= CntW'(RespDepth))
      else $error("tcdm_bank_responder: credits above RespDepth");
   a_credit_cover: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (32'(credits_q) + 32'(fifo_count)) <= RespDepth)
      else $error("tcdm_bank_responder: buffered responses exceed credits");
   a_full_no_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_full |-> (credits_q == '0))
      else $error("tcdm_bank_responder: FIFO full with credits left");
`endif

endmodule
`default_nettype wire

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Target-side endpoint of the variable-latency full-duplex crossbar. It sits between one crossbar target port and one fixed-latency SRAM bank.
- Accepts requests tagged with the initiator index and forwards them to the bank.
- Captures bank read data after a fixed latency and returns it with the same index under valid/ready backpressure.
- Grants are credit-based, so an accepted request always has a guaranteed response slot.

Parameters:
- NumIn, 4, number of crossbar initiators; index width IdxW = max(1, $clog2(NumIn)).
- ReqDataWidth, 32, opaque request payload width, passed unchanged to the bank.
- RespDataWidth, 32, bank read-data and response payload width.
- MemLatency, 1, cycles from mem_req_o to valid mem_rdata_i (>=1).
- RespDepth, 3, response buffer entries; must be >= MemLatency+2 for 1 req/cycle sustained.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  1  request from crossbar target port
- idx_i  in  IdxW  initiator index of the request
- wdata_i  in  ReqDataWidth  request payload
- gnt_o  out  1  request accepted
- mem_req_o  out  1  bank access strobe
- mem_wdata_o  out  ReqDataWidth  bank payload
- mem_rdata_i  in  RespDataWidth  bank data, valid MemLatency cycles after mem_req_o
- vld_o  out  1  response valid to crossbar
- rdy_i  in  1  response ready from crossbar
- idx_o  out  IdxW  initiator index of the response
- rdata_o  out  RespDataWidth  response data

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values:
  - credit counter = RespDepth.
  - Latency pipeline valid bits = 0.
  - FIFO empty: read pointer = write pointer = 0, count = 0.
  - Outputs after reset: vld_o=0, gnt_o=0, mem_req_o=0. idx_o and rdata_o are don't-care while vld_o=0.
- Grant:
  - gnt_o = req_i && (credits != 0). Combinational from req_i and the credit register only.
  - There is no combinational path from rdy_i to gnt_o.
  - mem_req_o = gnt_o; mem_wdata_o = wdata_i (pass-through).
- Credits:
  - Per cycle: credits_next = credits - grant + pop, where pop = vld_o && rdy_i.
  - Simultaneous grant and pop leaves the count unchanged.
  - Credits never exceed RespDepth and never go below 0; the bench asserts both bounds.
- Latency pipeline:
  - MemLatency stages, each carrying {valid, idx}. Stage 0 loads {gnt_o, idx_i}.
  - When the last stage is valid, {idx, mem_rdata_i} is pushed into the FIFO in that same cycle.
  - Every granted request produces exactly one response, writes included (rdata is then whatever the bank returns).
- Response FIFO:
  - RespDepth entries, registered output, no fall-through.
  - Head drives vld_o/idx_o/rdata_o. vld_o = (count != 0).
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo RespDepth; RespDepth need not be a power of two.
  - Push into a full FIFO is impossible by construction (credits); assert it.
- Latency: grant in cycle t gives mem_rdata_i sampled at t+MemLatency and vld_o high from t+MemLatency+1.
- Ordering: responses leave strictly in grant order. vld_o, idx_o and rdata_o are held stable while vld_o && !rdy_i.
- Reset mid-operation: in-flight and buffered responses are discarded and credits return to RespDepth. The crossbar is reset in the same cycle.
- Elaboration checks: $fatal if NumIn<1, MemLatency<1 or RespDepth<1. $warning if RespDepth < MemLatency+2.

Decomposition:
- Shared package tcdm_resp_pkg:
  - IdxW helper function.
  - Parameterised resp_t struct {idx, rdata} used by the FIFO and by the crossbar-side wrappers.
- One sub-module: tcdm_resp_fifo, a registered non-fall-through FIFO with push/pop/full/empty/count and arbitrary depth.
- Credit logic and the latency shift register stay in the top module.

Test Plan:
- Single read, MemLatency=1, idx_i=2, rdy_i=1: grant at cycle 0 → mem_req_o at 0, bank returns 0xDEADBEEF at 1 → vld_o=1, idx_o=2, rdata_o=0xDEADBEEF at cycle 2 only.
- Streaming: req_i=1 for 20 cycles, rdy_i=1, RespDepth=3 → gnt_o high all 20 cycles; 20 responses in order, indices matching.
- Backpressure: rdy_i=0, req_i held 1 → exactly 3 grants, then gnt_o=0. FIFO holds 3 responses with vld_o stable. Raising rdy_i for one cycle pops 1 → one further grant the following cycle.
- Simultaneous: credits=0 with a pop in the same cycle as req_i → no grant that cycle, grant next cycle; credits never exceed 3.
- Mixed indices 0,3,1,3 with random rdy_i (50%) → idx_o sequence 0,3,1,3 with matching rdata; rdata_o never changes while vld_o && !rdy_i.
- Reset asserted with 2 responses buffered and 1 in flight → next cycle vld_o=0, credits=3; a fresh request is granted immediately and its response arrives after MemLatency+1 cycles with no stale data.
